rfsoc_mm2s_seq: RTL and testbench

Sequencer for the DAC playback path. It turns the software-programmed start address, capture size and start/reset control bits into a stream of AXI DataMover MM2S commands and consumes the returned status words. It reports progress back to the register block: current address, pass count, last status and a sticky error. It sits between the RFSoC register block and the DataMover command/status AXI-Stream ports.

---
 rtl/rfsoc_mm2s_seq.sv | 204 ++++++++++++++++++++
 tb/tb_rfsoc_mm2s_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rfsoc_mm2s_seq.sv
`default_nettype none
// rfsoc_mm2s_seq: turns start/size control bits into AXI DataMover MM2S commands and tracks status.
// Optional status watchdog is compiled in with RFSOC_MM2S_SEQ_TIMEOUT_EN.
module rfsoc_mm2s_seq #(
  parameter int BURST_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic        sw_reset,
  input  logic [31:0] start_addr,
  input  logic [31:0] cap_size,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  output logic [71:0] cmd_tdata,
  input  logic        sts_tvalid,
  output logic        sts_tready,
  input  logic [7:0]  sts_tdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] current_addr,
  output logic [7:0]  run_cycles,
  output logic [7:0]  dm_status,
  output logic        mm2s_err
);

  localparam logic [31:0] BURST   = 32'(BURST_BYTES);
  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

  if (BURST_BYTES < 1 || BURST_BYTES > 8388607 || MAX_OUTSTANDING < 1 ||
      MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rfsoc_mm2s_seq: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t      state;
  logic        start_q;
  logic        abort_q;
  logic [31:0] addr;
  logic [31:0] remaining;
  logic [3:0]  tag;
  logic [3:0]  outstanding;

  function automatic logic [22:0] btt_of(input logic [31:0] rem);
    return (rem > BURST) ? BURST[22:0] : rem[22:0];
  endfunction

  function automatic logic [71:0] make_cmd(input logic [31:0] a, input logic [31:0] rem,
                                           input logic [3:0] t);
    return {4'h0, t, a, 1'b0, (rem <= BURST), 6'd0, 1'b1, btt_of(rem)};
  endfunction

  logic        cmd_hs, sts_hs, sts_dec, sts_bad, abort_now;
  logic [22:0] btt;
  logic [31:0] addr_nxt, rem_nxt;
  logic [3:0]  out_nxt, tag_nxt;

  assign cmd_hs    = cmd_tvalid & cmd_tready;
  assign sts_hs    = sts_tvalid & sts_tready;
  // Stray statuses (nothing outstanding) only refresh dm_status.
  assign sts_dec   = sts_hs & (outstanding != 4'd0);
  assign sts_bad   = sts_dec & ((sts_tdata[6:4] != 3'b000) | ~sts_tdata[7]);
  assign abort_now = abort_q | sw_reset | sts_bad;
  assign btt       = btt_of(remaining);
  assign addr_nxt  = addr + {9'd0, btt};
  assign rem_nxt   = remaining - {9'd0, btt};
  assign tag_nxt   = tag + 4'd1;
  assign out_nxt   = outstanding + {3'd0, cmd_hs} - {3'd0, sts_dec};
  assign busy      = (state != S_IDLE);

`ifdef RFSOC_MM2S_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
      tag          <= '0;
      outstanding  <= '0;
      cmd_tvalid   <= 1'b0;
      cmd_tdata    <= '0;
      sts_tready   <= 1'b0;
      done         <= 1'b0;
      current_addr <= '0;
      run_cycles   <= '0;
      dm_status    <= '0;
      mm2s_err     <= 1'b0;
`ifdef RFSOC_MM2S_SEQ_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      sts_tready  <= 1'b1;
      done        <= 1'b0;
      start_q     <= start;
      outstanding <= out_nxt;
      if (sts_hs) dm_status <= sts_tdata;
      if (sts_bad) mm2s_err <= 1'b1;
      if (cmd_hs) begin
        current_addr <= addr;
        addr         <= addr_nxt;
        remaining    <= rem_nxt;
        tag          <= tag_nxt;
      end
      // Abort requests are remembered so a stalled command can finish first.
      if (state != S_IDLE && (sw_reset || sts_bad)) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (cmd_hs) cmd_tvalid <= 1'b0;
          if (start && !start_q && !sw_reset && !cmd_tvalid) begin
            mm2s_err   <= 1'b0;
            run_cycles <= '0;
            tag        <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          addr      <= start_addr;
          remaining <= cap_size;
          if (sw_reset) begin
            state <= S_DRAIN;
          end else if (cap_size == 32'd0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cmd_tvalid <= 1'b1;
            cmd_tdata  <= make_cmd(start_addr, cap_size, tag);
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_hs) begin
            if (abort_now) begin
              cmd_tvalid <= 1'b0;
              state      <= S_DRAIN;
            end else if (rem_nxt == 32'd0) begin
              cmd_tvalid <= 1'b0;
              state      <= S_WAIT;
            end else if (out_nxt < MAX_OUT) begin
              cmd_tdata <= make_cmd(addr_nxt, rem_nxt, tag_nxt);
            end else begin
              cmd_tvalid <= 1'b0;
            end
          end else if (!cmd_tvalid) begin
            if (abort_now) begin
              state <= S_DRAIN;
            end else if (remaining == 32'd0) begin
              state <= S_WAIT;
            end else if (outstanding < MAX_OUT) begin
              cmd_tvalid <= 1'b1;
              cmd_tdata  <= make_cmd(addr, remaining, tag);
            end
          end
        end
        S_WAIT: begin
          if (abort_now) begin
            state <= S_DRAIN;
          end else if (outstanding == 4'd0) begin
            if (run_cycles != 8'hFF) run_cycles <= run_cycles + 8'd1;
            if (start) begin
              state <= S_LOAD;
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (outstanding == 4'd0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (sw_reset) begin
        mm2s_err   <= 1'b0;
        run_cycles <= '0;
      end

`ifdef RFSOC_MM2S_SEQ_TIMEOUT_EN
      if (outstanding == 4'd0 || sts_hs) begin
        to_cnt <= '0;
      end else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        to_cnt      <= '0;
        mm2s_err    <= 1'b1;
        dm_status   <= 8'h10;
        outstanding <= '0;
        state       <= S_IDLE;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rfsoc_mm2s_seq.sv
`default_nettype none
// tb_rfsoc_mm2s_seq: directed scenarios for the MM2S sequencer (BURST 4096, 2 outstanding).
module tb_rfsoc_mm2s_seq;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        sw_reset = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] cap_size = '0;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b1;
  logic [71:0] cmd_tdata;
  logic        sts_tvalid = 1'b0;
  logic        sts_tready;
  logic [7:0]  sts_tdata = '0;
  logic        busy, done, mm2s_err;
  logic [31:0] current_addr;
  logic [7:0]  run_cycles, dm_status;

  rfsoc_mm2s_seq #(.BURST_BYTES(4096), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstb(rstb), .start(start), .sw_reset(sw_reset),
    .start_addr(start_addr), .cap_size(cap_size),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
    .sts_tvalid(sts_tvalid), .sts_tready(sts_tready), .sts_tdata(sts_tdata),
    .busy(busy), .done(done), .current_addr(current_addr),
    .run_cycles(run_cycles), .dm_status(dm_status), .mm2s_err(mm2s_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncmd = 0, ndone = 0, nout = 0, max_out = 0;
  logic [71:0] cmd_log [0:63];

  // Handshakes are observed mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rstb) begin
      if (sts_tvalid && sts_tready && nout > 0) nout--;
      if (cmd_tvalid && cmd_tready) begin
        if (ncmd < 64) cmd_log[ncmd] = cmd_tdata;
        ncmd++;
        nout++;
      end
      if (nout > max_out) max_out = nout;
      if (done) ndone++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sts(input logic [7:0] s);
    sts_tvalid = 1'b1;
    sts_tdata  = s;
    step();
    sts_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if ({cmd_tvalid, busy, done, mm2s_err, sts_tready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {cmd_tvalid, busy, done, mm2s_err, sts_tready}); end
    n_cmp++; if ({current_addr, run_cycles, dm_status} !== 48'h0) begin
      n_bad++; $display("FAIL reset_regs: got %h expected 0", {current_addr, run_cycles, dm_status}); end
    rstb = 1'b1;
    step();
    n_cmp++; if (sts_tready !== 1'b1) begin
      n_bad++; $display("FAIL reset_sts_tready: got %b expected 1", sts_tready); end
  endtask

  task automatic test_single_run();
    logic [71:0] exp_cmd [3] = '{72'h00_10000000_00801000, 72'h01_10001000_00801000,
                                 72'h02_10002000_40800800};
    int c0 = ncmd, d0 = ndone;
    start_addr = 32'h1000_0000; cap_size = 32'h2800; start = 1'b1;
    step();
    n_cmp++; if (cmd_tvalid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t1_latency1: got valid=%b busy=%b expected valid=0 busy=1", cmd_tvalid, busy); end
    start = 1'b0;
    step();
    n_cmp++; if (cmd_tvalid !== 1'b1) begin
      n_bad++; $display("FAIL t1_latency2: got valid=%b expected 1", cmd_tvalid); end
    for (int i = 0; i < 20 && ncmd < c0 + 2; i++) step();
    repeat (50) step();
    n_cmp++; if (ncmd - c0 !== 2 || cmd_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL t1_outstanding_cap: got cmds=%0d valid=%b expected cmds=2 valid=0", ncmd - c0, cmd_tvalid); end
    n_cmp++; if (max_out !== 2) begin
      n_bad++; $display("FAIL t1_max_outstanding: got %0d expected 2", max_out); end
    send_sts(8'h80);
    for (int i = 0; i < 20 && ncmd < c0 + 3; i++) step();
    send_sts(8'h81);
    send_sts(8'h82);
    for (int i = 0; i < 20 && ndone < d0 + 1; i++) step();
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (cmd_log[c0 + k] !== exp_cmd[k]) begin
        n_bad++; $display("FAIL t1_cmd%0d: got %h expected %h", k, cmd_log[c0 + k], exp_cmd[k]); end
    end
    n_cmp++; if (ncmd - c0 !== 3 || ndone - d0 !== 1) begin
      n_bad++; $display("FAIL t1_counts: got cmds=%0d dones=%0d expected 3 and 1", ncmd - c0, ndone - d0); end
    n_cmp++; if ({run_cycles, dm_status, busy, mm2s_err} !== {8'd1, 8'h82, 2'b00}) begin
      n_bad++; $display("FAIL t1_status: got rc=%0d sts=%h busy=%b err=%b expected 1 82 0 0", run_cycles, dm_status, busy, mm2s_err); end
    n_cmp++; if (current_addr !== 32'h1000_2000) begin
      n_bad++; $display("FAIL t1_current_addr: got %h expected 10002000", current_addr); end
  endtask

  task automatic test_loop();
    logic [71:0] exp_cmd [3] = '{72'h00_20000000_40801000, 72'h01_20000000_40801000,
                                 72'h02_20000000_40801000};
    int c0 = ncmd, d0 = ndone;
    start_addr = 32'h2000_0000; cap_size = 32'h1000; start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 30 && ncmd < c0 + p + 1; i++) step();
      if (p == 2) start = 1'b0;
      send_sts(8'h80 | 8'(p));
    end
    for (int i = 0; i < 30 && ndone < d0 + 1; i++) step();
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (cmd_log[c0 + k] !== exp_cmd[k]) begin
        n_bad++; $display("FAIL t2_cmd%0d: got %h expected %h", k, cmd_log[c0 + k], exp_cmd[k]); end
    end
    n_cmp++; if (ncmd - c0 !== 3 || ndone - d0 !== 1) begin
      n_bad++; $display("FAIL t2_counts: got cmds=%0d dones=%0d expected 3 and 1", ncmd - c0, ndone - d0); end
    n_cmp++; if (run_cycles !== 8'd3 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t2_run_cycles: got rc=%0d busy=%b expected 3 0", run_cycles, busy); end
  endtask

  task automatic test_error();
    int c0 = ncmd, d0 = ndone;
    start_addr = 32'h1000_0000; cap_size = 32'h2800; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && ncmd < c0 + 2; i++) step();
    repeat (3) step();
    send_sts(8'h80);
    send_sts(8'h41);
    repeat (6) step();
    n_cmp++; if (ncmd - c0 !== 2 || ndone - d0 !== 0) begin
      n_bad++; $display("FAIL t3_counts: got cmds=%0d dones=%0d expected 2 and 0", ncmd - c0, ndone - d0); end
    n_cmp++; if ({mm2s_err, busy, dm_status, run_cycles} !== {2'b10, 8'h41, 8'd0}) begin
      n_bad++; $display("FAIL t3_error: got err=%b busy=%b sts=%h rc=%0d expected 1 0 41 0", mm2s_err, busy, dm_status, run_cycles); end
  endtask

  task automatic test_stall_abort();
    int c0 = ncmd, d0 = ndone;
    cmd_tready = 1'b0;
    start_addr = 32'h3000_0000; cap_size = 32'h2800; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) sw_reset = 1'b1;
      n_cmp++; if (cmd_tvalid !== 1'b1 || cmd_tdata !== 72'h00_30000000_00801000) begin
        n_bad++; $display("FAIL t4_hold%0d: got valid=%b data=%h expected 1 003000000000801000", i, cmd_tvalid, cmd_tdata); end
      step();
    end
    n_cmp++; if (mm2s_err !== 1'b0 || run_cycles !== 8'd0) begin
      n_bad++; $display("FAIL t4_cleared: got err=%b rc=%0d expected 0 0", mm2s_err, run_cycles); end
    cmd_tready = 1'b1;
    repeat (6) step();
    n_cmp++; if (ncmd - c0 !== 1 || cmd_tvalid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t4_drain: got cmds=%0d valid=%b busy=%b expected 1 0 1", ncmd - c0, cmd_tvalid, busy); end
    n_cmp++; if (current_addr !== 32'h3000_0000) begin
      n_bad++; $display("FAIL t4_current_addr: got %h expected 30000000", current_addr); end
    send_sts(8'h80);
    repeat (3) step();
    sw_reset = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || ndone - d0 !== 0 || run_cycles !== 8'd0) begin
      n_bad++; $display("FAIL t4_idle: got busy=%b dones=%0d rc=%0d expected 0 0 0", busy, ndone - d0, run_cycles); end
  endtask

  task automatic test_zero_size();
    int c0 = ncmd;
    cap_size = 32'd0; start = 1'b1;
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t5_cycle1: got done=%b busy=%b expected 0 1", done, busy); end
    start = 1'b0;
    step();
    n_cmp++; if (done !== 1'b1 || cmd_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL t5_done: got done=%b valid=%b expected 1 0", done, cmd_tvalid); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || ncmd !== c0) begin
      n_bad++; $display("FAIL t5_after: got done=%b busy=%b cmds=%0d expected 0 0 %0d", done, busy, ncmd, c0); end
  endtask

  task automatic test_stray_status();
    send_sts(8'h55);
    step();
    n_cmp++; if (dm_status !== 8'h55 || mm2s_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stray_status: got sts=%h err=%b busy=%b expected 55 0 0", dm_status, mm2s_err, busy); end
  endtask

`ifdef RFSOC_MM2S_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int d0 = ndone;
    start_addr = 32'h4000_0000; cap_size = 32'h1000; start = 1'b1;
    step();
    start = 1'b0;
    repeat (120) step();
    n_cmp++; if ({mm2s_err, dm_status, busy} !== {1'b1, 8'h10, 1'b0} || ndone !== d0) begin
      n_bad++; $display("FAIL timeout: got err=%b sts=%h busy=%b expected 1 10 0", mm2s_err, dm_status, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_loop();
    test_error();
    test_stall_abort();
    test_zero_size();
    test_stray_status();
`ifdef RFSOC_MM2S_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
